// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: the 2-bit predictor encoding,
// the PC increment for the fall-through path, and the entry field order.
// Latency: n/a (types/constants only). Backpressure: n/a.
package btb_pkg;

  // 2-bit saturating predictor state; the MSB is the taken prediction.
  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;  // strong not-taken
  localparam ctr_t CTR_WNT = 2'd1;  // weak not-taken (reset state)
  localparam ctr_t CTR_WT  = 2'd2;  // weak taken (state on allocation)
  localparam ctr_t CTR_ST  = 2'd3;  // strong taken

  // Sequential fetch advances by one 32-bit instruction.
  localparam int unsigned PC_INC = 4;

  // Entry record layout, MSB to LSB: valid, tag, target, ctr.
  // The tag and target widths depend on the table geometry, so the packed
  // struct itself is declared next to the table, in this field order.
  localparam int ENTRY_CTR_W = $bits(ctr_t);

endpackage

// File: rtl/branch_target_buffer_if.sv
// Lookup/update/statistics bundle between the IF/ID stages and the BTB.
// Latency: lookup signals are combinational, update is applied at the next edge.
// Backpressure: none; every lookup and update is accepted unconditionally.
// Ports: lookup_* (IF fetch PC and prediction), upd_* (ID resolution),
// invalidate_i (flush all valid bits), lookup_cnt_o/hit_cnt_o (statistics).
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              lookup_valid_i;
  logic [ADDR_W-1:0] lookup_pc_i;
  logic              hit_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_next_pc_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              invalidate_i;
  logic [CNT_W-1:0]  lookup_cnt_o;
  logic [CNT_W-1:0]  hit_cnt_o;

  // Pipeline side: drives fetch PC and resolutions, consumes predictions.
  modport master (
    output lookup_valid_i, lookup_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, invalidate_i,
    input  hit_o, pred_taken_o, pred_next_pc_o, lookup_cnt_o, hit_cnt_o
  );

  // BTB side.
  modport slave (
    input  lookup_valid_i, lookup_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, invalidate_i,
    output hit_o, pred_taken_o, pred_next_pc_o, lookup_cnt_o, hit_cnt_o
  );
endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating predictor next-state: count up on taken, down on not-taken.
// Latency: purely combinational.
// Backpressure: n/a. Ports: i_ctr (current state), i_taken (outcome), o_ctr_nxt.
module sat_counter2
  import btb_pkg::*;
(
  input  ctr_t i_ctr,
  input  logic i_taken,
  output ctr_t o_ctr_nxt
);

  always_comb begin
    o_ctr_nxt = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr_nxt = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr_nxt = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry 2-bit predictors and stats.
// Latency: zero-cycle lookup from registered state; updates visible next cycle.
// Backpressure: none. Ports: clk_i, rst_i (sync, active-high), bus (slave).
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    ctr_t              ctr;
  } entry_t;

  // Flop array rather than RAM: the lookup path must not add a cycle.
  entry_t           r_tbl [ENTRIES];
  logic [CNT_W-1:0] r_lookup_cnt;
  logic [CNT_W-1:0] r_hit_cnt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  entry_t           w_lk_ent;
  logic             w_hit;
  logic             w_pred_taken;

  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  entry_t           w_up_ent;
  logic             w_up_hit;
  ctr_t             w_up_ctr_nxt;

  // Instruction-alignment bits carry no addressing information.
  logic             w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{bus.lookup_pc_i[1:0], bus.upd_pc_i[1:0]};

  // Lookup: reads pre-update state, so a same-index update in this cycle
  // is not bypassed to the fetch.
  assign w_lk_idx     = bus.lookup_pc_i[IDX_W+1:2];
  assign w_lk_tag     = bus.lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign w_lk_ent     = r_tbl[w_lk_idx];
  assign w_hit        = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
  assign w_pred_taken = w_hit && w_lk_ent.ctr[1];

  assign bus.hit_o          = w_hit;
  assign bus.pred_taken_o   = w_pred_taken;
  assign bus.pred_next_pc_o = w_pred_taken ? w_lk_ent.target
                                           : bus.lookup_pc_i + ADDR_W'(PC_INC);
  assign bus.lookup_cnt_o   = r_lookup_cnt;
  assign bus.hit_cnt_o      = r_hit_cnt;

  assign w_up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign w_up_tag = bus.upd_pc_i[ADDR_W-1:IDX_W+2];
  assign w_up_ent = r_tbl[w_up_idx];
  assign w_up_hit = w_up_ent.valid && (w_up_ent.tag == w_up_tag);

  sat_counter2 u_sat_counter2 (
    .i_ctr     (w_up_ent.ctr),
    .i_taken   (bus.upd_taken_i),
    .o_ctr_nxt (w_up_ctr_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i].valid  <= 1'b0;
        r_tbl[i].tag    <= '0;
        r_tbl[i].target <= '0;
        r_tbl[i].ctr    <= CTR_WNT;
      end
      r_lookup_cnt <= '0;
      r_hit_cnt    <= '0;
    end else begin
      // Statistics keep counting through invalidation; they wrap naturally.
      if (bus.lookup_valid_i) begin
        r_lookup_cnt <= r_lookup_cnt + CNT_W'(1);
        if (w_hit) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end

      if (bus.invalidate_i) begin
        // Only valid bits clear; ctr/target are retained and the update drops.
        for (int i = 0; i < ENTRIES; i++) begin
          r_tbl[i].valid <= 1'b0;
        end
      end else if (bus.upd_valid_i) begin
        if (w_up_hit) begin
          r_tbl[w_up_idx].ctr <= w_up_ctr_nxt;
          if (bus.upd_taken_i) r_tbl[w_up_idx].target <= bus.upd_target_i;
        end else if (bus.upd_taken_i) begin
          // Allocate by overwrite; any alias at this index is evicted.
          r_tbl[w_up_idx] <= '{valid: 1'b1, tag: w_up_tag,
                               target: bus.upd_target_i, ctr: CTR_WT};
        end
      end
    end
  end

endmodule
